// File: rtl/laser_button_conditioner.sv
// laser_button_conditioner
// Synchronises and debounces a raw push-button, then emits one single-cycle
// trigger pulse per qualified press for the laser FSM's `b` input. A hold-off
// counter suppresses re-triggering while the downstream burst is running.
module laser_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic b_pulse,
    output logic btn_level,
    output logic busy
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    // A zero-length hold-off still needs a 1-bit counter so the vector is legal.
    localparam int LOCK_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_e;

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              btn_level_q, btn_level_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              b_pulse_q, b_pulse_d;
    logic              busy_q, busy_d;
    logic              press_qualified;

    // Two-flop synchroniser chain; only s2 feeds the debounce logic.
    always_comb begin
        s1_d = btn_raw;
        s2_d = s1_q;
    end

    // Debounce FSM next state, shared counter and debounced level.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        btn_level_d     = btn_level_q;
        press_qualified = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = ST_PRESSED;
                    btn_level_d     = 1'b1;
                    press_qualified = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!s2_q) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT_LOW: begin
                if (s2_q) begin
                    // Release bounce: back to PRESSED, level never dropped.
                    state_d     = ST_PRESSED;
                    cnt_d       = '0;
                    btn_level_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    btn_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulse generation and hold-off counter; a press during hold-off is swallowed.
    always_comb begin
        b_pulse_d  = 1'b0;
        lock_cnt_d = lock_cnt_q;
        if (press_qualified && (lock_cnt_q == '0)) begin
            b_pulse_d  = 1'b1;
            lock_cnt_d = LOCK_LOAD;
        end else if (lock_cnt_q != '0) begin
            lock_cnt_d = lock_cnt_q - LOCK_W'(1);
        end
        busy_d = (lock_cnt_d != '0);
    end

    // State register: everything clears asynchronously, including any pulse in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
            lock_cnt_q  <= '0;
            b_pulse_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_level_q <= btn_level_d;
            lock_cnt_q  <= lock_cnt_d;
            b_pulse_q   <= b_pulse_d;
            busy_q      <= busy_d;
        end
    end

    assign b_pulse   = b_pulse_q;
    assign btn_level = btn_level_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_laser_button_conditioner.sv
// Self-checking bench for laser_button_conditioner: table-driven per-cycle
// vectors on the default instance plus hand-written lockout, reset and
// laser-integration sequences.
module tb_laser_button_conditioner;

    logic clk;
    logic rst_n;
    logic btn_raw;
    logic btn_lk;
    logic b_pulse, btn_level, busy;
    logic lk_pulse, lk_level, lk_busy;
    logic nl_pulse, nl_level, nl_busy;

    int n_cmp;
    int n_err;

    // Default parameters.
    laser_button_conditioner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .b_pulse   (b_pulse),
        .btn_level (btn_level),
        .busy      (busy)
    );

    // Long hold-off for the suppression test.
    laser_button_conditioner #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(20)) dut_lk (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_lk),
        .b_pulse   (lk_pulse),
        .btn_level (lk_level),
        .busy      (lk_busy)
    );

    // Hold-off disabled; shares the default instance's button.
    laser_button_conditioner #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(0)) dut_nl (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .b_pulse   (nl_pulse),
        .btn_level (nl_level),
        .busy      (nl_busy)
    );

    // Reference laser FSM: a pulse on b starts a 3-cycle burst on x.
    logic [1:0] laser_st;
    logic       laser_x;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) laser_st <= 2'd0;
        else begin
            case (laser_st)
                2'd0:    laser_st <= b_pulse ? 2'd1 : 2'd0;
                2'd1:    laser_st <= 2'd2;
                2'd2:    laser_st <= 2'd3;
                default: laser_st <= 2'd0;
            endcase
        end
    end
    assign laser_x = (laser_st != 2'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        logic pulse;
        logic level;
        logic busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic btn, input logic pulse, input logic level, input logic bsy);
        vec_t v;
        v.btn = btn; v.pulse = pulse; v.level = level; v.busy = bsy;
        vecs.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulse"}, 32'(b_pulse), 0);
        check({tag, "_level"}, 32'(btn_level), 0);
        check({tag, "_busy"},  32'(busy), 0);
    endtask

    initial begin
        logic glitch_press [13];
        logic glitch_rel   [13];
        int   x_total;
        int   x_rises;
        logic x_prev;

        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        btn_lk  = 1'b0;

        // ---- Vector table (row i = outputs after the i-th edge of a segment) ----
        glitch_press = '{1,0,1,1,0,0,0,0,0,0,0,0,0};
        glitch_rel   = '{0,1,0,0,1,1,1,1,1,1,1,1,1};
        // Clean press: pulse after edge 5, level from edge 5, busy edges 5..7.
        for (int i = 0; i < 12; i++) add_vec(1'b1, i == 5, i >= 5, (i >= 5) && (i <= 7));
        // Clean release: level falls at edge 5.
        for (int i = 0; i < 8; i++)  add_vec(1'b0, 1'b0, i < 5, 1'b0);
        // Press-side bounce: rejected, nothing moves.
        for (int i = 0; i < 13; i++) add_vec(glitch_press[i], 1'b0, 1'b0, 1'b0);
        // Second clean press.
        for (int i = 0; i < 12; i++) add_vec(1'b1, i == 5, i >= 5, (i >= 5) && (i <= 7));
        // Release-side bounce while held: level stays high, no extra pulse.
        for (int i = 0; i < 13; i++) add_vec(glitch_rel[i], 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  add_vec(1'b0, 1'b0, i < 5, 1'b0);

        // ---- Reset then idle ----
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero($sformatf("rst%0d", i));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_all_zero($sformatf("idle%0d", i));
            check($sformatf("idle%0d_nl_busy", i), 32'(nl_busy), 0);
        end

        // ---- Table-driven sequence ----
        for (int r = 0; r < vecs.size(); r++) begin
            btn_raw = vecs[r].btn;
            step();
            check($sformatf("row%0d_pulse", r), 32'(b_pulse),   32'(vecs[r].pulse));
            check($sformatf("row%0d_level", r), 32'(btn_level), 32'(vecs[r].level));
            check($sformatf("row%0d_busy", r),  32'(busy),      32'(vecs[r].busy));
            check($sformatf("row%0d_nl_pulse", r), 32'(nl_pulse), 32'(vecs[r].pulse));
            check($sformatf("row%0d_nl_level", r), 32'(nl_level), 32'(vecs[r].level));
            check($sformatf("row%0d_nl_busy", r),  32'(nl_busy),  0);
        end

        // ---- Lockout suppression, LOCKOUT_CYCLES=20 ----
        // Press edges 0..7, release 8..13, press 14..21, release 22..29, press 30+.
        for (int i = 0; i < 38; i++) begin
            logic e_pulse, e_busy, e_level;
            btn_lk  = (i < 8) || (i >= 14 && i < 22) || (i >= 30);
            e_pulse = (i == 5) || (i == 35);
            e_busy  = (i >= 5 && i <= 24) || (i >= 35);
            e_level = (i >= 5 && i <= 12) || (i >= 19 && i <= 26) || (i >= 35);
            step();
            check($sformatf("lk%0d_pulse", i), 32'(lk_pulse), 32'(e_pulse));
            check($sformatf("lk%0d_busy", i),  32'(lk_busy),  32'(e_busy));
            check($sformatf("lk%0d_level", i), 32'(lk_level), 32'(e_level));
        end
        btn_lk = 1'b0;

        // ---- Reset while in WAIT_HIGH ----
        btn_raw = 1'b1;
        for (int i = 0; i < 4; i++) step();   // WAIT_HIGH after edge 2, still there after edge 3
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_wh_now");
        step();
        check_all_zero("rst_wh_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rqwh%0d_pulse", i), 32'(b_pulse),   32'(i == 5));
            check($sformatf("rqwh%0d_level", i), 32'(btn_level), 32'(i >= 5));
        end

        // ---- Reset during the pulse cycle ----
        btn_raw = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("pre_pc_level", 32'(btn_level), 0);
        btn_raw = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("pc_pulse_seen", 32'(b_pulse), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_pc_now");
        step();
        check_all_zero("rst_pc_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rqpc%0d_pulse", i), 32'(b_pulse), 32'(i == 5));
            check($sformatf("rqpc%0d_busy", i),  32'(busy),    32'(i >= 5 && i <= 7));
        end

        // ---- Integration with the laser FSM ----
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("int_idle_x", 32'(laser_x), 0);
        x_total = 0;
        x_rises = 0;
        x_prev  = laser_x;
        for (int i = 0; i < 40; i++) begin
            btn_raw = (i < 30);
            step();
            if (laser_x) x_total++;
            if (laser_x && !x_prev) x_rises++;
            x_prev = laser_x;
        end
        check("laser_x_cycles", 32'(x_total), 3);
        check("laser_x_bursts", 32'(x_rises), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/laser_button_conditioner.md
# laser_button_conditioner

Upstream input stage for the laser trigger FSM. It takes the raw, asynchronous, bouncing push-button and synchronises and debounces it. It then emits exactly one single-cycle trigger pulse per qualified press, and that pulse drives the laser FSM's button input `b` directly. A hold-off window blocks re-triggering while the downstream laser burst is still running.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive identical synchronised samples needed to accept a level change. Legal range is ≥ 2.
- `LOCKOUT_CYCLES`, default 3: number of cycles after a pulse during which new presses produce no pulse. Legal range is ≥ 0; 0 disables the hold-off. The default matches the 3-cycle laser burst.
- `clk`  input  1  the single system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset. It clears all state immediately; release is synchronous to `clk`.
- `btn_raw`  input  1  raw button level. It is asynchronous to `clk` and may bounce.
- `b_pulse`  output  1  registered one-cycle trigger, connected to the laser FSM `b` input.
- `btn_level`  output  1  registered debounced button level.
- `busy`  output  1  registered; high while the hold-off counter is nonzero.

## Operation
- Synchroniser: a two-flop chain, `btn_raw` → `s1` → `s2`. Both flops reset to 0. Only `s2` is used by the logic below.
- Debounce FSM has 4 states, IDLE, WAIT_HIGH, PRESSED and WAIT_LOW. It shares one counter `cnt` of width clog2(DEBOUNCE_CYCLES)+1.
  - IDLE: if `s2`=1, go to WAIT_HIGH with `cnt`=1. Otherwise stay.
  - WAIT_HIGH: if `s2`=0, go to IDLE with `cnt`=0. If `s2`=1 and `cnt`=DEBOUNCE_CYCLES−1, go to PRESSED. Otherwise increment `cnt`.
  - PRESSED: if `s2`=0, go to WAIT_LOW with `cnt`=1. Otherwise stay.
  - WAIT_LOW: if `s2`=1, go to PRESSED with `cnt`=0. If `s2`=0 and `cnt`=DEBOUNCE_CYCLES−1, go to IDLE. Otherwise increment `cnt`.
  - Unreachable encodings go to IDLE.
- `btn_level` is registered. It is set at the edge the FSM enters PRESSED and cleared at the edge it enters IDLE from WAIT_LOW. It therefore stays high through PRESSED and WAIT_LOW.
- Pulse generation uses `lock_cnt`, of width clog2(LOCKOUT_CYCLES+1).
  - At the edge the FSM moves WAIT_HIGH→PRESSED, if `lock_cnt`=0 (pre-edge value): set `b_pulse`=1 for one cycle and load `lock_cnt`=LOCKOUT_CYCLES.
  - If `lock_cnt`≠0 at that edge, the press is suppressed. No pulse is issued, `btn_level` still rises, and `lock_cnt` is not reloaded.
  - Otherwise `b_pulse`=0, and `lock_cnt` decrements each cycle while nonzero.
- `busy` = (`lock_cnt`≠0), registered alongside `lock_cnt`.
- Holding the button produces no further pulses. A new pulse requires a full return to IDLE followed by a new qualified press.
- Bounces shorter than DEBOUNCE_CYCLES samples in WAIT_HIGH or WAIT_LOW are rejected, with no output change.

## Timing
- Reset values: `s1`=`s2`=0, state IDLE, `cnt`=0, `lock_cnt`=0, `b_pulse`=0, `btn_level`=0, `busy`=0.
- Press latency, with edge 0 being the first edge that samples `btn_raw`=1 into `s1`, for a clean input:
  - `s2`=1 after edge 1.
  - IDLE→WAIT_HIGH at edge 2.
  - PRESSED, `b_pulse`=1 and `btn_level`=1 all take effect at edge DEBOUNCE_CYCLES+1 (edge 5 at default).
- `b_pulse` stays high for exactly one clock period.
- Release latency: `btn_level` falls at edge DEBOUNCE_CYCLES+1 after the first edge that samples `btn_raw`=0.
- Hold-off: with a pulse high during cycle t, `busy` is high for cycles t … t+LOCKOUT_CYCLES−1.
  - A PRESSED entry at an edge where `busy`=0 yields a pulse.
  - With LOCKOUT_CYCLES=0, `busy` is never asserted.
- The earliest re-trigger, including release and re-press debounce, is never inside the laser's 3-cycle burst at the defaults.
- Reset asserted mid-press or mid-lockout clears everything at once, and any pulse in flight is dropped. After release, a button still held low-to-high must re-qualify from IDLE.

## Test plan
- Reset then idle: `rst_n`=0 for 3 cycles, then 1, with `btn_raw`=0 for 20 cycles → all outputs 0 throughout.
- Clean press, defaults: `btn_raw` rises before edge 0 and is held 20 cycles → `b_pulse`=1 only in the cycle after edge 5, `btn_level`=1 from edge 5, and `busy` high for exactly 3 cycles starting with the pulse cycle.
- Bounce rejection: `btn_raw` pattern 1,0,1,1,0 (one cycle each), then 0 → no pulse and `btn_level` stays 0. The same glitch pattern on release while held → `btn_level` stays 1 and no extra pulse.
- Lockout suppression: LOCKOUT_CYCLES=20, two clean presses separated by a 6-cycle release → first press pulses; second press raises `btn_level` with no pulse; a third press after `busy` falls pulses.
- Reset mid-operation: assert `rst_n`=0 while in WAIT_HIGH, and separately in the pulse cycle → outputs go to 0 immediately, with no pulse after release until a fresh qualified press.
- Integration with the laser FSM: connect `b_pulse` to `b` and hold the button 30 cycles → laser `x` is high for exactly 3 consecutive cycles, once.
